addsub_pipe: RTL
================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, signalling that the operand set is presented.
REQ-005 The block SHALL have port in_ready, output, 1, signalling that the block can accept an operand set this cycle.
REQ-006 The block SHALL have port a, input, WIDTH, operand A; ignored in accumulate modes.
REQ-007 The block SHALL have port b, input, WIDTH, operand B.
REQ-008 The block SHALL have port mode, input, 2, operation select: 00 A+B, 01 A-B, 10 ACC+B, 11 ACC-B.
REQ-009 The block SHALL have port clr_acc, input, 1, a one-cycle accumulator clear request.
REQ-010 The block SHALL have port out_valid, output, 1, signalling that the result register holds an unconsumed result.
REQ-011 The block SHALL have port out_ready, input, 1, signalling that the consumer accepts the result.
REQ-012 The block SHALL have port result, output, WIDTH, the registered result.
REQ-013 The block SHALL have port carry, output, 1, the unsigned carry-out; add modes only, otherwise 0.
REQ-014 The block SHALL have port borrow, output, 1, the unsigned borrow; subtract modes only, set when minuend < subtrahend, otherwise 0.
REQ-015 The block SHALL have port overflow, output, 1, the two's-complement signed overflow of the operation.
REQ-016 The block SHALL have port zero, output, 1, set when result == 0.

Function
REQ-017 Accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL be combinational: !out_valid || out_ready, giving full throughput with a single output register.
REQ-019 Latency SHALL be 1 cycle: result and flags of an accepted operation are valid on the edge after accept, with out_valid=1.
REQ-020 out_valid, result and flags SHALL hold stable while out_valid && !out_ready.
REQ-021 When out_ready=1 and no accept occurs, out_valid SHALL go to 0 on the next edge.
REQ-022 When an accept and a consume coincide, the new result SHALL replace the old one with out_valid staying 1.
REQ-023 Subtraction SHALL be computed as X + ~Y + 1.
REQ-024 In subtract modes, borrow SHALL equal !carry_internal and carry SHALL be forced to 0; the raw adder carry is never exported in subtract modes.
REQ-025 overflow SHALL be 1 when both operands, after B inversion, have equal sign and the result sign differs.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH unless ADDSUB_SAT_EN is defined.
REQ-027 An internal WIDTH-bit accumulator acc SHALL be updated to the result on every accept in modes 10/11; modes 00/01 SHALL NOT change acc.
REQ-028 clr_acc SHALL set acc to 0 on the edge where it is sampled high.
REQ-029 If clr_acc coincides with an accepted mode-10/11 operation, clear SHALL apply first: the operation uses ACC=0, and acc takes the new result.
REQ-030 clr_acc SHALL NOT affect out_valid or the result register.
REQ-031 An input not accepted (in_ready=0) SHALL leave acc and all outputs unchanged.

Reset
REQ-032 With rst_n=0 at a rising edge, the block SHALL clear out_valid, result, carry, borrow, overflow and acc to 0 and set zero to 1.
REQ-033 in_ready SHALL be 1 the first cycle after reset.
REQ-034 Reset SHALL override any accept, consume or clr_acc in the same cycle, and any pending result SHALL be discarded.

Configuration
REQ-035 Macro ADDSUB_SAT_EN, when defined, SHALL enable signed saturation: on overflow, result clamps to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); the clamped value is also written to acc in modes 10/11.
REQ-036 With ADDSUB_SAT_EN defined, the overflow flag SHALL still report 1 when clamping occurs.
REQ-037 Without ADDSUB_SAT_EN, results SHALL wrap, with no saturation logic present.

Verification (WIDTH=8)
REQ-038 The bench SHALL cover: mode 01, a=12, b=7 -> result 0x05, borrow 0, carry 0, overflow 0, out_valid 1 cycle after accept.
REQ-039 The bench SHALL cover: mode 01, a=7, b=12 -> result 0xFB, borrow 1, carry 0, zero 0.
REQ-040 The bench SHALL cover: mode 00, a=100, b=100 -> overflow 1, carry 0; result 0xC8 without the macro, 0x7F with ADDSUB_SAT_EN.
REQ-041 The bench SHALL cover: out_ready held 0 after one accept -> in_ready 0 and result held; raising out_ready with in_valid=1 -> back-to-back accepts, one result per cycle.
REQ-042 The bench SHALL cover: clr_acc, then five accepted mode-10 operations with b=3 -> final result 15; clr_acc with mode 11, b=1 in the same cycle -> result 0xFF, borrow 1.
REQ-043 The bench SHALL cover: rst_n=0 while out_valid=1 and acc=15 -> out_valid 0, zero 1; next mode-10 operation with b=2 -> result 2.

Source files
------------

// File: rtl/addsub_pipe.sv
// addsub_pipe: single-stage add/subtract unit with an internal accumulator
// and a valid/ready handshake on both sides.
//
// The operation is chosen by mode:
//   00 A+B   01 A-B   10 ACC+B   11 ACC-B
// Subtraction is X + ~Y + 1. In subtract modes the exported borrow is the
// inverse of the adder carry, and the carry output is held at 0.
//
// Optional feature macro: ADDSUB_SAT_EN
//   When defined, a signed overflow clamps the result to the most positive
//   or most negative WIDTH-bit value. The clamped value also becomes the new
//   accumulator value in modes 10/11. When undefined, results wrap modulo
//   2^WIDTH and no clamping logic is built.
//
// Port names follow the block's published interface so it can be dropped
// into existing integration code unchanged.

module addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  // Registered state: the output stage and the running accumulator.
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;

  // Handshake and datapath intermediates.
  logic             w_inReady;
  logic             w_accept;
  logic             w_isAccMode;
  logic             w_isSubMode;
  logic [WIDTH-1:0] w_accOperand;
  logic [WIDTH-1:0] w_opX;
  logic [WIDTH-1:0] w_opY;
  logic [WIDTH:0]   w_rawSum;
  logic [WIDTH-1:0] w_sum;
  logic             w_carryOut;
  logic             w_overflow;
  logic [WIDTH-1:0] w_finalResult;
  logic             w_carryFlag;
  logic             w_borrowFlag;
  logic             w_zeroFlag;

  // A single output register gives full throughput: a new operand set can be
  // taken whenever the register is empty or is being drained this cycle.
  assign w_inReady   = !r_outValid || out_ready;
  assign w_accept    = in_valid && w_inReady;
  assign w_isAccMode = mode[1];
  assign w_isSubMode = mode[0];

  // A clear arriving together with an accumulate operation takes effect
  // first, so the operation sees an accumulator of zero.
  assign w_accOperand = clr_acc ? '0 : r_acc;

  // Operand selection, B inversion for subtraction and the shared adder.
  always_comb begin
    w_opX    = w_isAccMode ? w_accOperand : a;
    w_opY    = w_isSubMode ? ~b : b;
    w_rawSum = {1'b0, w_opX} + {1'b0, w_opY} + {{WIDTH{1'b0}}, w_isSubMode};
  end

  assign w_sum      = w_rawSum[WIDTH-1:0];
  assign w_carryOut = w_rawSum[WIDTH];

  // Signed overflow: the adder inputs (after inversion) agree in sign but
  // the sum does not.
  assign w_overflow = (w_opX[WIDTH-1] == w_opY[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_opX[WIDTH-1]);

  // Carry is only meaningful for additions; borrow only for subtractions,
  // where it is the complement of the raw adder carry.
  assign w_carryFlag  = !w_isSubMode && w_carryOut;
  assign w_borrowFlag =  w_isSubMode && !w_carryOut;

`ifdef ADDSUB_SAT_EN
  logic [WIDTH-1:0] w_satMax;
  logic [WIDTH-1:0] w_satMin;

  assign w_satMax = {1'b0, {(WIDTH-1){1'b1}}};
  assign w_satMin = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow both adder inputs share a sign, which tells us the
  // direction: two negatives underflow, two positives overflow.
  always_comb begin
    w_finalResult = w_sum;
    if (w_overflow) begin
      w_finalResult = w_opX[WIDTH-1] ? w_satMin : w_satMax;
    end
  end
`else
  // Plain modular arithmetic: the adder output is the result.
  always_comb begin
    w_finalResult = w_sum;
  end
`endif

  assign w_zeroFlag = (w_finalResult == '0);

  // Output stage: load on accept, drain when the consumer takes the result,
  // otherwise hold everything stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_result   <= w_finalResult;
      r_carry    <= w_carryFlag;
      r_borrow   <= w_borrowFlag;
      r_overflow <= w_overflow;
      r_zero     <= w_zeroFlag;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Accumulator: takes the result of accepted accumulate operations; a
  // standalone clear zeroes it without touching the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_accept && w_isAccMode) begin
      r_acc <= w_finalResult;
    end else if (clr_acc) begin
      r_acc <= '0;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
